// File: rtl/sr_flag_pkg.sv
// ----------------------------------------------------------------------------
// sr_flag_pkg
// Shared constants, the command encoding and the command decode function
// used by the SR flag arbiter and anything that needs to predict it.
// ----------------------------------------------------------------------------
package sr_flag_pkg;

    localparam int unsigned NREQ_DEF  = 4;
    localparam int unsigned NFLAG_DEF = 8;

    typedef enum logic [1:0] {
        CMD_NOP = 2'd0,
        CMD_SET = 2'd1,
        CMD_CLR = 2'd2,
        CMD_BAD = 2'd3
    } cmd_e;

    // Classify one requester command; out-of-range index or set+clr is illegal.
    function automatic cmd_e cmd_decode(
        input logic        set,
        input logic        clr,
        input int unsigned idx,
        input int unsigned nflag
    );
        if (idx >= nflag)      return CMD_BAD;
        else if (set && clr)   return CMD_BAD;
        else if (set)          return CMD_SET;
        else if (clr)          return CMD_CLR;
        else                   return CMD_NOP;
    endfunction

endpackage

// File: rtl/sr_flag_bank.sv
// ----------------------------------------------------------------------------
// sr_flag_bank
// Bank of NFLAG SR flip-flops. Each bit is set by s, reset by r, and the
// whole bank is cleared synchronously by clear_all (which wins over s/r).
//
// Ports:
//   clk         clock, rising edge
//   reset       asynchronous active-low reset
//   i_s         per-flag set pulses
//   i_r         per-flag reset pulses
//   i_clear_all synchronous clear of every flag
//   o_q         current flag state
// ----------------------------------------------------------------------------
module sr_flag_bank #(
    parameter int unsigned NFLAG = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [NFLAG-1:0] i_s,
    input  logic [NFLAG-1:0] i_r,
    input  logic             i_clear_all,
    output logic [NFLAG-1:0] o_q
);

    logic [NFLAG-1:0] r_q;

    // SR storage; s and r are never both high on one bit, so order is moot.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_q <= '0;
        end else if (i_clear_all) begin
            r_q <= '0;
        end else begin
            r_q <= (r_q & ~i_r) | i_s;
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/sr_flag_arbiter.sv
// ----------------------------------------------------------------------------
// sr_flag_arbiter
// Round-robin arbiter sharing a bank of SR flags among NREQ requesters.
// One command is granted per cycle and turned into a registered one-cycle
// set or reset pulse on the addressed flag; illegal commands get an err
// pulse alongside their grant instead.
//
// Ports:
//   clk        clock, rising edge
//   reset      asynchronous active-low reset
//   req        per-requester request, held until granted
//   cmd_set    per-requester set command
//   cmd_clr    per-requester clear command
//   cmd_idx    per-requester flag index, requester i at [i*IDXW +: IDXW]
//   clear_all  clear every flag and suspend arbitration this cycle
//   gnt        one-hot one-cycle grant pulse
//   err        one-cycle error pulse coincident with gnt
//   flag_s     registered set pulses to the bank
//   flag_r     registered reset pulses to the bank
//   flag_q     current flag state
// ----------------------------------------------------------------------------
module sr_flag_arbiter
    import sr_flag_pkg::*;
#(
    parameter int unsigned NREQ  = NREQ_DEF,
    parameter int unsigned NFLAG = NFLAG_DEF,
    parameter int unsigned IDXW  = $clog2(NFLAG)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ-1:0]      cmd_set,
    input  logic [NREQ-1:0]      cmd_clr,
    input  logic [NREQ*IDXW-1:0] cmd_idx,
    input  logic                 clear_all,
    output logic [NREQ-1:0]      gnt,
    output logic [NREQ-1:0]      err,
    output logic [NFLAG-1:0]     flag_s,
    output logic [NFLAG-1:0]     flag_r,
    output logic [NFLAG-1:0]     flag_q
);

    localparam int unsigned PTRW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [PTRW-1:0]  r_ptr;
    logic [NREQ-1:0]  r_gnt;
    logic [NREQ-1:0]  r_err;
    logic [NFLAG-1:0] r_s;
    logic [NFLAG-1:0] r_r;

    logic [NREQ-1:0]  w_elig;
    logic             w_found;
    int unsigned      w_win;
    int unsigned      w_cand;
    logic [IDXW-1:0]  w_idx;
    cmd_e             w_cmd;
    logic [PTRW-1:0]  w_ptr_nxt;
    logic [NREQ-1:0]  w_gnt_nxt;
    logic [NREQ-1:0]  w_err_nxt;
    logic [NFLAG-1:0] w_s_nxt;
    logic [NFLAG-1:0] w_r_nxt;

    // Arbitration and command decode for the next registered grant/pulse.
    always_comb begin
        // A requester holding req through its gnt cycle must not win twice.
        w_elig    = req & ~r_gnt;
        w_found   = 1'b0;
        w_win     = '0;
        w_cand    = '0;
        w_idx     = '0;
        w_cmd     = CMD_NOP;
        w_ptr_nxt = r_ptr;
        w_gnt_nxt = '0;
        w_err_nxt = '0;
        w_s_nxt   = '0;
        w_r_nxt   = '0;

        // First eligible requester at or after the pointer, wrapping.
        for (int unsigned o = 0; o < NREQ; o++) begin
            w_cand = 32'(r_ptr) + o;
            if (w_cand >= NREQ) begin
                w_cand = w_cand - NREQ;
            end
            if (!w_found && w_elig[PTRW'(w_cand)]) begin
                w_found = 1'b1;
                w_win   = w_cand;
            end
        end

        // clear_all suspends arbitration; requests simply stay pending.
        if (w_found && !clear_all) begin
            w_idx = IDXW'(cmd_idx >> (w_win * IDXW));
            w_cmd = cmd_decode(cmd_set[PTRW'(w_win)], cmd_clr[PTRW'(w_win)],
                               32'(w_idx), NFLAG);
            w_gnt_nxt[PTRW'(w_win)] = 1'b1;
            w_ptr_nxt = (w_win + 1 >= NREQ) ? '0 : PTRW'(w_win + 1);
            case (w_cmd)
                CMD_SET: w_s_nxt[w_idx] = 1'b1;
                CMD_CLR: w_r_nxt[w_idx] = 1'b1;
                CMD_BAD: w_err_nxt[PTRW'(w_win)] = 1'b1;
                default: ;
            endcase
        end
    end

    // Grant, error, pulse and pointer registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ptr <= '0;
            r_gnt <= '0;
            r_err <= '0;
            r_s   <= '0;
            r_r   <= '0;
        end else begin
            r_ptr <= w_ptr_nxt;
            r_gnt <= w_gnt_nxt;
            r_err <= w_err_nxt;
            r_s   <= w_s_nxt;
            r_r   <= w_r_nxt;
        end
    end

    sr_flag_bank #(
        .NFLAG (NFLAG)
    ) u_bank (
        .clk         (clk),
        .reset       (reset),
        .i_s         (r_s),
        .i_r         (r_r),
        .i_clear_all (clear_all),
        .o_q         (flag_q)
    );

    assign gnt    = r_gnt;
    assign err    = r_err;
    assign flag_s = r_s;
    assign flag_r = r_r;

    // Structural guarantees on the registered outputs.
    a_gnt_onehot : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(r_gnt));
    a_sr_exclusive : assert property (@(posedge clk) disable iff (!reset)
        $onehot0(r_s | r_r));
    a_err_with_gnt : assert property (@(posedge clk) disable iff (!reset)
        (r_err & ~r_gnt) == '0);

endmodule

// File: tb/tb_sr_flag_arbiter.sv
// ----------------------------------------------------------------------------
// tb_sr_flag_arbiter
// Directed and randomized checks of sr_flag_arbiter against a cycle model
// built from the arbitration rules. A second instance with NFLAG=6 covers
// out-of-range flag indices.
// ----------------------------------------------------------------------------
module tb_sr_flag_arbiter;
    import sr_flag_pkg::*;

    localparam int unsigned NREQ  = 4;
    localparam int unsigned NFLAG = 8;
    localparam int unsigned IDXW  = 3;
    localparam int unsigned NF6   = 6;
    localparam int unsigned IW6   = 3;

    logic clk = 1'b0;
    logic reset;
    logic [NREQ-1:0]      req, cmd_set, cmd_clr;
    logic [NREQ*IDXW-1:0] cmd_idx;
    logic                 clear_all;
    logic [NREQ-1:0]      gnt, err;
    logic [NFLAG-1:0]     flag_s, flag_r, flag_q;

    logic [NREQ-1:0]      req6, set6, clr6;
    logic [NREQ*IW6-1:0]  idx6;
    logic                 ca6;
    logic [NREQ-1:0]      gnt6, err6;
    logic [NF6-1:0]       s6, r6, q6;

    always #5 clk = ~clk;

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NFLAG), .IDXW(IDXW)) u_dut (
        .clk(clk), .reset(reset), .req(req), .cmd_set(cmd_set), .cmd_clr(cmd_clr),
        .cmd_idx(cmd_idx), .clear_all(clear_all), .gnt(gnt), .err(err),
        .flag_s(flag_s), .flag_r(flag_r), .flag_q(flag_q)
    );

    sr_flag_arbiter #(.NREQ(NREQ), .NFLAG(NF6), .IDXW(IW6)) u_dut6 (
        .clk(clk), .reset(reset), .req(req6), .cmd_set(set6), .cmd_clr(clr6),
        .cmd_idx(idx6), .clear_all(ca6), .gnt(gnt6), .err(err6),
        .flag_s(s6), .flag_r(r6), .flag_q(q6)
    );

    int n_total = 0;
    int n_bad   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model state: what the outputs should be during the current cycle.
    int               m_rr;
    logic [NREQ-1:0]  m_gnt, m_err;
    logic [NFLAG-1:0] m_s, m_r, m_q;
    bit hold_mode;
    bit rand_mode;

    task automatic model_reset();
        m_rr = 0; m_gnt = '0; m_err = '0; m_s = '0; m_r = '0; m_q = '0;
    endtask

    function automatic int unsigned idx_of(input int w);
        int unsigned v;
        v = 32'(cmd_idx);
        return (v >> (w * IDXW)) % (1 << IDXW);
    endfunction

    // Advance the model across one rising edge using this cycle's inputs.
    task automatic model_edge();
        int w;
        logic [NREQ-1:0]  ng, ne;
        logic [NFLAG-1:0] ns, nr;
        int unsigned ix;
        if (clear_all) m_q = '0;
        else begin
            for (int f = 0; f < NFLAG; f++) begin
                if (m_s[f]) m_q[f] = 1'b1;
                if (m_r[f]) m_q[f] = 1'b0;
            end
        end
        ng = '0; ne = '0; ns = '0; nr = '0; w = -1;
        if (!clear_all) begin
            for (int o = 0; o < NREQ; o++) begin
                int c;
                c = (m_rr + o) % NREQ;
                if (w < 0 && req[c] && !m_gnt[c]) w = c;
            end
        end
        if (w >= 0) begin
            ng[w] = 1'b1;
            m_rr  = (w + 1) % NREQ;
            ix    = idx_of(w);
            case (cmd_decode(cmd_set[w], cmd_clr[w], ix, NFLAG))
                CMD_SET: ns[ix] = 1'b1;
                CMD_CLR: nr[ix] = 1'b1;
                CMD_BAD: ne[w]  = 1'b1;
                default: ;
            endcase
        end
        m_gnt = ng; m_err = ne; m_s = ns; m_r = nr;
    endtask

    task automatic issue(input int r, input logic s, input logic c, input int unsigned ix);
        req[r] = 1'b1;
        cmd_set[r] = s;
        cmd_clr[r] = c;
        cmd_idx[r*IDXW +: IDXW] = IDXW'(ix);
    endtask

    // One clock: model edge, compare at the falling edge, then requester reaction.
    task automatic cycle();
        @(posedge clk);
        model_edge();
        @(negedge clk);
        check("gnt",    32'(gnt),    32'(m_gnt));
        check("err",    32'(err),    32'(m_err));
        check("flag_s", 32'(flag_s), 32'(m_s));
        check("flag_r", 32'(flag_r), 32'(m_r));
        check("flag_q", 32'(flag_q), 32'(m_q));
        for (int i = 0; i < NREQ; i++) begin
            if (m_gnt[i] && !hold_mode) req[i] = 1'b0;
        end
        if (rand_mode) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!req[i] && $urandom_range(1, 0) == 1)
                    issue(i, 1'($urandom_range(1, 0)), 1'($urandom_range(1, 0)),
                          $urandom_range(NFLAG - 1, 0));
            end
            clear_all = ($urandom_range(9, 0) == 0);
        end
    endtask

    task automatic wait_gnt(input int r, input string tag);
        bit got;
        got = 1'b0;
        for (int t = 0; t < 20 && !got; t++) begin
            cycle();
            if (m_gnt[r]) got = 1'b1;
        end
        check(tag, 32'(got), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; req = '0; cmd_set = '0; cmd_clr = '0; cmd_idx = '0; clear_all = 1'b0;
        req6 = '0; set6 = '0; clr6 = '0; idx6 = '0; ca6 = 1'b0;
        hold_mode = 1'b0; rand_mode = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_gnt", 32'(gnt), 32'd0);
        check("rst_q",   32'(flag_q), 32'd0);
        reset = 1'b1;

        // Idle after reset
        for (int n = 0; n < 10; n++) begin
            cycle();
            check("idle_gnt", 32'(gnt | err), 32'd0);
            check("idle_q",   32'(flag_q | flag_s | flag_r), 32'd0);
        end

        // Round robin with every requester continuously requesting
        hold_mode = 1'b1; req = '1;
        for (int n = 0; n < 12; n++) begin
            cycle();
            check("rr_order", 32'(gnt), 32'd1 << (n % 4));
        end
        req = '0; hold_mode = 1'b0;
        cycle();

        // Single set then clear on flag 5
        issue(0, 1'b1, 1'b0, 5);
        cycle();
        check("set_gnt", 32'(gnt), 32'h1);
        check("set_s",   32'(flag_s), 32'h20);
        cycle();
        check("set_q",   32'(flag_q), 32'h20);
        issue(0, 1'b0, 1'b1, 5);
        cycle();
        check("clr_r",   32'(flag_r), 32'h20);
        cycle();
        check("clr_q",   32'(flag_q), 32'h00);

        // Illegal set+clr from requester 2
        issue(2, 1'b1, 1'b1, 3);
        wait_gnt(2, "bad_wait");
        check("bad_gnt", 32'(gnt), 32'h4);
        check("bad_err", 32'(err), 32'h4);
        check("bad_sr",  32'(flag_s | flag_r), 32'h0);
        cycle();
        check("bad_q",   32'(flag_q), 32'h0);

        // Out-of-range index on the NFLAG=6 instance, then a legal set
        req6 = 4'b0010; set6 = 4'b0010; idx6 = 12'd7 << IW6;
        cycle();
        check("oor_gnt", 32'(gnt6), 32'h2);
        check("oor_err", 32'(err6), 32'h2);
        check("oor_s",   32'(s6 | r6), 32'h0);
        req6 = '0;
        cycle();
        check("oor_q",   32'(q6), 32'h0);
        req6 = 4'b0010; idx6 = 12'd5 << IW6;
        cycle();
        check("f6_gnt",  32'(gnt6), 32'h2);
        check("f6_err",  32'(err6), 32'h0);
        check("f6_s",    32'(s6), 32'h20);
        req6 = '0;
        cycle();
        check("f6_q",    32'(q6), 32'h20);

        // Fill the bank, then clear_all against a pending set
        for (int j = 0; j < NFLAG; j++) begin
            issue(0, 1'b1, 1'b0, j);
            wait_gnt(0, "fill_wait");
        end
        cycle();
        check("fill_q", 32'(flag_q), 32'hFF);
        issue(3, 1'b1, 1'b0, 0);
        clear_all = 1'b1;
        cycle();
        check("ca_gnt", 32'(gnt), 32'h0);
        check("ca_q",   32'(flag_q), 32'h00);
        clear_all = 1'b0;
        cycle();
        check("ca_resume_gnt", 32'(gnt), 32'h8);
        cycle();
        check("ca_resume_q",   32'(flag_q), 32'h01);

        // Randomized traffic with occasional clear_all
        rand_mode = 1'b1;
        repeat (600) cycle();
        rand_mode = 1'b0; clear_all = 1'b0; req = '0;
        repeat (3) cycle();

        // Asynchronous reset while a grant and set pulse are live
        issue(1, 1'b1, 1'b0, 2);
        wait_gnt(1, "mid_wait");
        check("mid_gnt", 32'(gnt), 32'h2);
        check("mid_s",   32'(flag_s), 32'h04);
        req = '0;
        #2 reset = 1'b0;
        #1;
        check("mid_rst_gnt", 32'(gnt | err), 32'h0);
        check("mid_rst_sr",  32'(flag_s | flag_r), 32'h0);
        check("mid_rst_q",   32'(flag_q), 32'h0);
        model_reset();
        repeat (2) @(negedge clk);
        reset = 1'b1;
        hold_mode = 1'b1; req = '1; cmd_set = '0; cmd_clr = '0;
        cycle();
        check("restart_gnt", 32'(gnt), 32'h1);
        hold_mode = 1'b0; req = '0;
        repeat (3) cycle();

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
